// File: rtl/n64_vmode_sequencer_pkg.sv
// n64_vmode_sequencer_pkg: shared types and constants for the
// video-mode sequencer (states, vinfo/sync bit positions, helpers).
package n64_vmode_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_LOCKED  = 3'd1,
    ST_PENDING = 3'd2,
    ST_REQ     = 3'd3,
    ST_SETTLE  = 3'd4
  } vseq_state_e;

  // vinfo_i = {data_cnt[1:0], vmode, n64_480i}
  localparam int VI_DCNT_HI = 3;
  localparam int VI_DCNT_LO = 2;
  localparam int VI_VMODE   = 1;
  localparam int VI_480I    = 0;

  // Sync nibble bit positions
  localparam int SY_NVSYNC = 3;
  localparam int SY_NHSYNC = 1;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/n64_vmode_sequencer_if.sv
// n64_vmode_sequencer_if: req/ack reconfiguration handshake.
// master drives cfg_req/cfg_vmode/cfg_480i, slave returns cfg_ack.
interface n64_vmode_sequencer_if;
  logic cfg_req;
  logic cfg_vmode;
  logic cfg_480i;
  logic cfg_ack;

  modport master (
    output cfg_req,
    output cfg_vmode,
    output cfg_480i,
    input  cfg_ack
  );

  modport slave (
    input  cfg_req,
    input  cfg_vmode,
    input  cfg_480i,
    output cfg_ack
  );
endinterface

// File: rtl/n64_vmode_sequencer_frame_tick.sv
// n64_frame_tick: one-VCLK frame strobe on nVSYNC rising edge,
// qualified by the sync cycle (nDSYNC low) and registered.
// Ports: VCLK, nRST, nDSYNC, Sync_pre, Sync_cur -> tick.
module n64_frame_tick
  import n64_vmode_sequencer_pkg::*;
(
  input  logic       VCLK,
  input  logic       nRST,
  input  logic       nDSYNC,
  input  logic [3:0] Sync_pre,
  input  logic [3:0] Sync_cur,
  output logic       tick
);

  logic vs_rise;
  logic unused_sync;

  assign vs_rise = !nDSYNC
                 & !Sync_pre[SY_NVSYNC]
                 &  Sync_cur[SY_NVSYNC];

  assign unused_sync = ^{Sync_pre[2:0], Sync_cur[2:0]};

  always_ff @(posedge VCLK or negedge nRST) begin
    if (!nRST) tick <= 1'b0;
    else       tick <= vs_rise;
  end

endmodule

// File: rtl/n64_vmode_sequencer.sv
// n64_vmode_sequencer: debounces vmode/480i over frames and commits
// changes to the datapath via cfg req/ack, blanking during reconfig.
// Ports: VCLK, nRST, nDSYNC, Sync_pre/cur, vinfo_i, cfg (master),
//        vmode_o, n64_480i_o, vid_blank, cfg_err, state_o.
module n64_vmode_sequencer
  import n64_vmode_sequencer_pkg::*;
#(
  parameter int STABLE_FRAMES  = 3,
  parameter int TIMEOUT_FRAMES = 4,
  parameter int BLANK_FRAMES   = 1
) (
  input  logic                    VCLK,
  input  logic                    nRST,
  input  logic                    nDSYNC,
  input  logic [3:0]              Sync_pre,
  input  logic [3:0]              Sync_cur,
  input  logic [3:0]              vinfo_i,
  n64_vmode_sequencer_if.master   cfg,
  output logic                    vmode_o,
  output logic                    n64_480i_o,
  output logic                    vid_blank,
  output logic                    cfg_err,
  output logic [2:0]              state_o
);

  localparam logic [3:0] SF = 4'(STABLE_FRAMES);
  localparam logic [3:0] TF = 4'(TIMEOUT_FRAMES);
  localparam logic [3:0] BF = 4'(BLANK_FRAMES);

  vseq_state_e state;
  logic        tick;
  logic [1:0]  s;
  logic [1:0]  cand;
  logic [1:0]  committed;
  logic [3:0]  stable_cnt;
  logic [3:0]  to_cnt;
  logic [3:0]  blank_cnt;
  logic [3:0]  stab_nxt;
  logic [3:0]  to_inc;
  logic        to_hit;
  logic        unused_dcnt;

  n64_frame_tick u_tick (
    .VCLK     (VCLK),
    .nRST     (nRST),
    .nDSYNC   (nDSYNC),
    .Sync_pre (Sync_pre),
    .Sync_cur (Sync_cur),
    .tick     (tick)
  );

  assign s = {vinfo_i[VI_VMODE], vinfo_i[VI_480I]};
  assign committed = {vmode_o, n64_480i_o};
  assign unused_dcnt = ^vinfo_i[VI_DCNT_HI:VI_DCNT_LO];

  // count after this tick: restart at 1 on a new candidate
  assign stab_nxt = (s == cand) ? sat_inc(stable_cnt) : 4'd1;
  assign to_inc   = sat_inc(to_cnt);
  assign to_hit   = tick && (to_inc >= TF);

  assign state_o = state;

  always_ff @(posedge VCLK or negedge nRST) begin
    if (!nRST) begin
      state         <= ST_INIT;
      cand          <= 2'b01;
      vmode_o       <= 1'b0;
      n64_480i_o    <= 1'b1;
      cfg.cfg_req   <= 1'b0;
      cfg.cfg_vmode <= 1'b0;
      cfg.cfg_480i  <= 1'b1;
      vid_blank     <= 1'b1;
      cfg_err       <= 1'b0;
      stable_cnt    <= 4'd0;
      to_cnt        <= 4'd0;
      blank_cnt     <= 4'd0;
    end else begin
      unique case (state)
        ST_INIT: begin
          if (tick) begin
            cand <= s;
            if (stab_nxt >= SF) begin
              state         <= ST_REQ;
              cfg.cfg_req   <= 1'b1;
              cfg.cfg_vmode <= s[1];
              cfg.cfg_480i  <= s[0];
              vid_blank     <= 1'b1;
              stable_cnt    <= 4'd0;
              to_cnt        <= 4'd0;
            end else begin
              stable_cnt <= stab_nxt;
            end
          end
        end

        ST_LOCKED: begin
          if (tick && s != committed) begin
            cand <= s;
            if (SF <= 4'd1) begin
              state         <= ST_REQ;
              cfg.cfg_req   <= 1'b1;
              cfg.cfg_vmode <= s[1];
              cfg.cfg_480i  <= s[0];
              vid_blank     <= 1'b1;
              stable_cnt    <= 4'd0;
              to_cnt        <= 4'd0;
            end else begin
              state      <= ST_PENDING;
              stable_cnt <= 4'd1;
            end
          end
        end

        ST_PENDING: begin
          if (tick) begin
            if (s == committed) begin
              state      <= ST_LOCKED;
              vid_blank  <= 1'b0;
              stable_cnt <= 4'd0;
              to_cnt     <= 4'd0;
            end else begin
              cand <= s;
              if (stab_nxt >= SF) begin
                state         <= ST_REQ;
                cfg.cfg_req   <= 1'b1;
                cfg.cfg_vmode <= s[1];
                cfg.cfg_480i  <= s[0];
                vid_blank     <= 1'b1;
                stable_cnt    <= 4'd0;
                to_cnt        <= 4'd0;
              end else begin
                stable_cnt <= stab_nxt;
              end
            end
          end
        end

        ST_REQ: begin
          if (cfg.cfg_ack || to_hit) begin
            vmode_o     <= cand[1];
            n64_480i_o  <= cand[0];
            cfg.cfg_req <= 1'b0;
            // ack has priority: a timeout in the same cycle is not an error
            if (!cfg.cfg_ack) cfg_err <= 1'b1;
            if (BF == 4'd0) begin
              state      <= ST_LOCKED;
              vid_blank  <= 1'b0;
              stable_cnt <= 4'd0;
              to_cnt     <= 4'd0;
            end else begin
              state     <= ST_SETTLE;
              blank_cnt <= BF;
            end
          end else if (tick) begin
            to_cnt <= to_inc;
          end
        end

        ST_SETTLE: begin
          if (tick) begin
            if (blank_cnt <= 4'd1) begin
              state      <= ST_LOCKED;
              vid_blank  <= 1'b0;
              blank_cnt  <= 4'd0;
              stable_cnt <= 4'd0;
              to_cnt     <= 4'd0;
            end else begin
              blank_cnt <= blank_cnt - 4'd1;
            end
          end
        end

        default: begin
          state     <= ST_INIT;
          vid_blank <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_n64_vmode_sequencer.sv
// tb_n64_vmode_sequencer: directed frame sequences with
// hand-computed expectations for the vmode sequencer.
module tb_n64_vmode_sequencer;

  logic       VCLK = 1'b0;
  logic       nRST = 1'b0;
  logic       nDSYNC = 1'b1;
  logic [3:0] Sync_pre = 4'hF;
  logic [3:0] Sync_cur = 4'hF;
  logic [3:0] vinfo_i = 4'h0;
  logic       vmode_o;
  logic       n64_480i_o;
  logic       vid_blank;
  logic       cfg_err;
  logic [2:0] state_o;

  int n_cmp = 0;
  int n_bad = 0;

  n64_vmode_sequencer_if cfg ();

  n64_vmode_sequencer dut (
    .VCLK       (VCLK),
    .nRST       (nRST),
    .nDSYNC     (nDSYNC),
    .Sync_pre   (Sync_pre),
    .Sync_cur   (Sync_cur),
    .vinfo_i    (vinfo_i),
    .cfg        (cfg.master),
    .vmode_o    (vmode_o),
    .n64_480i_o (n64_480i_o),
    .vid_blank  (vid_blank),
    .cfg_err    (cfg_err),
    .state_o    (state_o)
  );

  always #5 VCLK = ~VCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag,
                       input logic [7:0] got,
                       input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  // one frame: sync cycle with nVSYNC rising, tick registered next
  // edge, FSM reacts on the edge after; returns once that is visible
  task automatic frame(input logic [1:0] v, input logic ack);
    @(negedge VCLK);
    vinfo_i  = {2'b10, v};
    nDSYNC   = 1'b0;
    Sync_pre = 4'b0111;
    Sync_cur = 4'b1111;
    @(negedge VCLK);
    nDSYNC   = 1'b1;
    Sync_pre = 4'hF;
    cfg.cfg_ack = ack;
    @(negedge VCLK);
    cfg.cfg_ack = 1'b0;
  endtask

  task automatic chk_mode(input string tag,
                          input logic [2:0] st,
                          input logic req,
                          input logic blank);
    check({tag, "_st"}, 8'(state_o), 8'(st));
    check({tag, "_req"}, 8'(cfg.cfg_req), 8'(req));
    check({tag, "_blk"}, 8'(vid_blank), 8'(blank));
  endtask

  initial begin
    cfg.cfg_ack = 1'b0;
    repeat (3) @(negedge VCLK);

    check("rst_state", 8'(state_o), 8'd0);
    check("rst_vmode", 8'(vmode_o), 8'd0);
    check("rst_480i", 8'(n64_480i_o), 8'd1);
    check("rst_req", 8'(cfg.cfg_req), 8'd0);
    check("rst_cvm", 8'(cfg.cfg_vmode), 8'd0);
    check("rst_c480", 8'(cfg.cfg_480i), 8'd1);
    check("rst_blank", 8'(vid_blank), 8'd1);
    check("rst_err", 8'(cfg_err), 8'd0);

    nRST = 1'b1;

    // 1: bring-up at NTSC/240p, ack 2 VCLK after req
    frame(2'b00, 1'b0);
    frame(2'b00, 1'b0);
    chk_mode("t1_f2", 3'd0, 1'b0, 1'b1);
    frame(2'b00, 1'b0);
    chk_mode("t1_f3", 3'd3, 1'b1, 1'b1);
    check("t1_cvm", 8'(cfg.cfg_vmode), 8'd0);
    check("t1_c480", 8'(cfg.cfg_480i), 8'd0);
    @(negedge VCLK);
    check("t1_hold", 8'(cfg.cfg_req), 8'd1);
    cfg.cfg_ack = 1'b1;
    @(negedge VCLK);
    cfg.cfg_ack = 1'b0;
    chk_mode("t1_ack", 3'd4, 1'b0, 1'b1);
    check("t1_vm", 8'(vmode_o), 8'd0);
    check("t1_480", 8'(n64_480i_o), 8'd0);
    check("t1_err", 8'(cfg_err), 8'd0);
    frame(2'b00, 1'b0);
    chk_mode("t1_lock", 3'd1, 1'b0, 1'b0);

    // ack outside REQ does nothing
    cfg.cfg_ack = 1'b1;
    repeat (3) @(negedge VCLK);
    cfg.cfg_ack = 1'b0;
    chk_mode("stray_ack", 3'd1, 1'b0, 1'b0);

    // 2: single glitch frame
    frame(2'b10, 1'b0);
    chk_mode("t2_pend", 3'd2, 1'b0, 1'b0);
    frame(2'b00, 1'b0);
    chk_mode("t2_back", 3'd1, 1'b0, 1'b0);
    check("t2_vm", 8'(vmode_o), 8'd0);

    // 3: 01 then 11,11,11 -> candidate restarts
    frame(2'b01, 1'b0);
    chk_mode("t3_a", 3'd2, 1'b0, 1'b0);
    frame(2'b11, 1'b0);
    frame(2'b11, 1'b0);
    chk_mode("t3_c", 3'd2, 1'b0, 1'b0);
    frame(2'b11, 1'b0);
    chk_mode("t3_req", 3'd3, 1'b1, 1'b1);
    check("t3_cvm", 8'(cfg.cfg_vmode), 8'd1);
    check("t3_c480", 8'(cfg.cfg_480i), 8'd1);

    // 4: no ack -> forced commit on 4th tick
    frame(2'b00, 1'b0);
    frame(2'b00, 1'b0);
    frame(2'b00, 1'b0);
    chk_mode("t4_wait", 3'd3, 1'b1, 1'b1);
    check("t4_cvm_hold", 8'(cfg.cfg_vmode), 8'd1);
    frame(2'b11, 1'b0);
    chk_mode("t4_to", 3'd4, 1'b0, 1'b1);
    check("t4_err", 8'(cfg_err), 8'd1);
    check("t4_vm", 8'(vmode_o), 8'd1);
    check("t4_480", 8'(n64_480i_o), 8'd1);
    frame(2'b11, 1'b0);
    chk_mode("t4_lock", 3'd1, 1'b0, 1'b0);
    check("t4_sticky", 8'(cfg_err), 8'd1);

    // 5: ack on the same cycle as the timeout tick
    @(negedge VCLK);
    nRST = 1'b0;
    @(negedge VCLK);
    nRST = 1'b1;
    check("t5_rst_err", 8'(cfg_err), 8'd0);
    repeat (3) frame(2'b00, 1'b0);
    chk_mode("t5_req", 3'd3, 1'b1, 1'b1);
    repeat (3) frame(2'b00, 1'b0);
    chk_mode("t5_wait", 3'd3, 1'b1, 1'b1);
    frame(2'b00, 1'b1);
    chk_mode("t5_cmt", 3'd4, 1'b0, 1'b1);
    check("t5_err", 8'(cfg_err), 8'd0);
    check("t5_480", 8'(n64_480i_o), 8'd0);

    // 6: reset while requesting
    frame(2'b00, 1'b0);
    chk_mode("t6_lock", 3'd1, 1'b0, 1'b0);
    repeat (3) frame(2'b10, 1'b0);
    chk_mode("t6_req", 3'd3, 1'b1, 1'b1);
    @(negedge VCLK);
    #2 nRST = 1'b0;
    #1;
    chk_mode("t6_rst", 3'd0, 1'b0, 1'b1);
    check("t6_vm", 8'(vmode_o), 8'd0);
    check("t6_480", 8'(n64_480i_o), 8'd1);
    @(negedge VCLK);
    nRST = 1'b1;
    @(negedge VCLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
